// File: rtl/if_stage_pkg.sv
// if_stage_pkg: constants and state encoding shared by fetch and hazard logic
package if_stage_pkg;
  localparam logic [5:0]  OP_HALT   = 6'h3f;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] RESET_PC  = 32'h0;
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;
  function automatic logic is_halt(input logic [5:0] op);
    return op == OP_HALT;
  endfunction
endpackage

// File: rtl/if_stage_pipe_reg.sv
// pipe_reg: enabled register with synchronous reset/clear to a fixed value
module pipe_reg #(
  parameter int W = 32,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst || clr) q <= CLR_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/if_stage.sv
// if_stage: PC, instruction fetch and IF/ID register with halt and stall tracking
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        haz_pcEn,
  input  logic        haz_ifidEn,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] d_instr,
  output logic [31:0] d_pcplus4,
  output logic        d_valid,
  output logic        halted,
  output logic [15:0] stall_cnt
);
  state_t state;
  logic [31:0] pc, pc4, pc_next;
  logic run, pc_en, ifid_en, flush;
  assign run = state == RUN;
  assign pc4 = pc + 32'd4;
  assign pc_en = run & haz_pcEn;
  assign ifid_en = run & haz_ifidEn;
  // a taken branch only squashes IF/ID when the PC actually redirects
  assign flush = ifid_en & haz_pcEn & br_taken;
  assign pc_next = br_taken ? br_target : pc4;
  assign imem_addr = pc;
  pipe_reg #(.W(32), .CLR_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .en(pc_en), .clr(1'b0), .d(pc_next), .q(pc)
  );
  pipe_reg #(.W(32), .CLR_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .rst(rst), .en(ifid_en), .clr(flush), .d(imem_data), .q(d_instr)
  );
  pipe_reg #(.W(32), .CLR_VAL(32'h0)) u_pcplus4 (
    .clk(clk), .rst(rst), .en(ifid_en), .clr(flush), .d(pc4), .q(d_pcplus4)
  );
  pipe_reg #(.W(1), .CLR_VAL(1'b0)) u_valid (
    .clk(clk), .rst(rst), .en(ifid_en), .clr(flush), .d(1'b1), .q(d_valid)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= RUN;
      halted <= 1'b0;
      stall_cnt <= '0;
    end else if (run) begin
      if (d_valid && is_halt(d_instr[31:26])) begin
        state <= HALTED;
        halted <= 1'b1;
      end
      if (!haz_pcEn && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: vector table plus halt sequence, checked through an expectation queue
module tb_if_stage;
  logic clk = 1'b0, rst, haz_pcEn, haz_ifidEn, br_taken, d_valid, halted;
  logic [31:0] br_target, imem_data, imem_addr, d_instr, d_pcplus4;
  logic [15:0] stall_cnt;
  logic [31:0] halt_addr;
  int tests = 0, fails = 0;

  typedef struct {
    logic rst, pe, ie, br;
    logic [31:0] tgt, pc, instr, pp4;
    logic v, h;
    logic [15:0] cnt;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .haz_pcEn(haz_pcEn), .haz_ifidEn(haz_ifidEn),
    .br_taken(br_taken), .br_target(br_target), .imem_data(imem_data),
    .imem_addr(imem_addr), .d_instr(d_instr), .d_pcplus4(d_pcplus4),
    .d_valid(d_valid), .halted(halted), .stall_cnt(stall_cnt)
  );

  always_comb
    imem_data = imem_addr == 32'h0 ? 32'h20010005 :
                imem_addr == 32'h4 ? 32'h20020006 :
                imem_addr == halt_addr ? 32'hFC000000 :
                {16'h00A5, imem_addr[15:0]};

  task automatic apply(input string name, input vec_t v);
    vec_t e;
    rst = v.rst; haz_pcEn = v.pe; haz_ifidEn = v.ie; br_taken = v.br; br_target = v.tgt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    tests++;
    if (imem_addr !== e.pc || d_instr !== e.instr || d_pcplus4 !== e.pp4 ||
        d_valid !== e.v || halted !== e.h || stall_cnt !== e.cnt) begin
      fails++;
      $display("FAIL %s: got pc=%h instr=%h pp4=%h v=%b h=%b cnt=%0d, want pc=%h instr=%h pp4=%h v=%b h=%b cnt=%0d",
               name, imem_addr, d_instr, d_pcplus4, d_valid, halted, stall_cnt,
               e.pc, e.instr, e.pp4, e.v, e.h, e.cnt);
    end
  endtask

  initial begin
    halt_addr = 32'hDEAD0000;
    rst = 1'b1; haz_pcEn = 1'b1; haz_ifidEn = 1'b1; br_taken = 1'b0; br_target = '0;
    //            rst pe ie br tgt           pc            instr         pp4           v  h  cnt
    tbl.push_back('{1, 1, 1, 1, 32'h40,       32'h0,        32'h0,        32'h0,        0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 32'h0,        32'h4,        32'h20010005, 32'h4,        1, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 32'h0,        32'h8,        32'h20020006, 32'h8,        1, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 32'h0,        32'hC,        32'h00A50008, 32'hC,        1, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 32'h0,        32'h10,       32'h00A5000C, 32'h10,       1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        32'h10,       32'h00A5000C, 32'h10,       1, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 32'h99,       32'h10,       32'h00A5000C, 32'h10,       1, 0, 2});
    tbl.push_back('{0, 1, 1, 0, 32'h0,        32'h14,       32'h00A50010, 32'h14,       1, 0, 2});
    tbl.push_back('{0, 1, 1, 1, 32'hC,        32'hC,        32'h0,        32'h0,        0, 0, 2});
    tbl.push_back('{0, 1, 1, 1, 32'h40,       32'h40,       32'h0,        32'h0,        0, 0, 2});
    tbl.push_back('{0, 1, 1, 0, 32'h0,        32'h44,       32'h00A50040, 32'h44,       1, 0, 2});
    tbl.push_back('{0, 0, 0, 1, 32'h80,       32'h44,       32'h00A50040, 32'h44,       1, 0, 3});
    tbl.push_back('{0, 1, 1, 1, 32'h80,       32'h80,       32'h0,        32'h0,        0, 0, 3});
    tbl.push_back('{0, 1, 0, 0, 32'h0,        32'h84,       32'h0,        32'h0,        0, 0, 3});
    tbl.push_back('{0, 1, 1, 0, 32'h0,        32'h88,       32'h00A50084, 32'h88,       1, 0, 3});
    tbl.push_back('{0, 1, 1, 1, 32'h101,      32'h101,      32'h0,        32'h0,        0, 0, 3});
    tbl.push_back('{0, 1, 1, 0, 32'h0,        32'h105,      32'h00A50101, 32'h105,      1, 0, 3});
    tbl.push_back('{0, 1, 1, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 0, 3});
    tbl.push_back('{0, 1, 1, 0, 32'h0,        32'h0,        32'h00A5FFFC, 32'h0,        1, 0, 3});
    tbl.push_back('{0, 1, 1, 0, 32'h0,        32'h4,        32'h20010005, 32'h4,        1, 0, 3});
    tbl.push_back('{0, 1, 0, 1, 32'h200,      32'h200,      32'h20010005, 32'h4,        1, 0, 3});
    tbl.push_back('{0, 1, 1, 0, 32'h0,        32'h204,      32'h00A50200, 32'h204,      1, 0, 3});
    for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);

    halt_addr = 32'h8;
    apply("halt_rst",   '{1, 1, 1, 0, 32'h0, 32'h0,  32'h0,        32'h0,  0, 0, 0});
    apply("halt_f0",    '{0, 1, 1, 0, 32'h0, 32'h4,  32'h20010005, 32'h4,  1, 0, 0});
    apply("halt_f4",    '{0, 1, 1, 0, 32'h0, 32'h8,  32'h20020006, 32'h8,  1, 0, 0});
    apply("halt_seen",  '{0, 1, 1, 0, 32'h0, 32'hC,  32'hFC000000, 32'hC,  1, 0, 0});
    apply("halt_enter", '{0, 1, 1, 0, 32'h0, 32'h10, 32'h00A5000C, 32'h10, 1, 1, 0});
    for (int i = 0; i < 10; i++)
      apply($sformatf("halt_hold%0d", i),
            '{0, i[0], 1, ~i[0], 32'h300, 32'h10, 32'h00A5000C, 32'h10, 1, 1, 0});
    apply("halt_exit",  '{1, 1, 1, 1, 32'h300, 32'h0, 32'h0,        32'h0,  0, 0, 0});
    apply("halt_resume",'{0, 1, 1, 0, 32'h0,   32'h4, 32'h20010005, 32'h4,  1, 0, 0});

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL: haz_pcEn  input  1  PC update enable from hazard detection (0 = hold PC).
REQ-004 SHALL: haz_ifidEn  input  1  IF/ID register enable from hazard detection (0 = hold IF/ID).
REQ-005 SHALL: br_taken  input  1  branch/jump resolved taken in ID this cycle.
REQ-006 SHALL: br_target  input  32  redirect address, valid when br_taken=1.
REQ-007 SHALL: imem_data  input  32  instruction word for imem_addr, combinational read, same cycle.
REQ-008 SHALL: imem_addr  output  32  current PC.
REQ-009 SHALL: d_instr  output  32  IF/ID instruction register, drives hazard unit and decode.
REQ-010 SHALL: d_pcplus4  output  32  IF/ID copy of fetch PC+4.
REQ-011 SHALL: d_valid  output  1  IF/ID holds a real fetched instruction (0 = bubble).
REQ-012 SHALL: halted  output  1  fetch permanently stopped by halt instruction.
REQ-013 SHALL: stall_cnt  output  16  count of cycles with haz_pcEn=0 while not halted.

Function
REQ-014 SHALL: state machine with states RUN and HALTED; only RUN fetches.
REQ-015 SHALL: RUN -> HALTED on the edge where d_valid=1 and d_instr[31:26]=6'h3f; HALTED exits only on rst.
REQ-016 SHALL: halted = 1 exactly when state is HALTED (registered, one cycle after halt op is visible in d_instr).
REQ-017 SHALL: in HALTED, PC, d_instr, d_pcplus4, d_valid, stall_cnt hold; all inputs ignored.
REQ-018 SHALL: in RUN, per-edge priority: stall > branch > sequential.
REQ-019 SHALL: stall: haz_pcEn=0 holds PC; haz_ifidEn=0 holds d_instr/d_pcplus4/d_valid; each enable acts independently; br_taken ignored while haz_pcEn=0.
REQ-020 SHALL: branch (haz_pcEn=1, br_taken=1): PC <= br_target; IF/ID loads bubble (d_instr=32'h0, d_pcplus4=0, d_valid=0) if haz_ifidEn=1.
REQ-021 SHALL: sequential: PC <= PC+4 (modulo 2^32, 0xFFFFFFFC wraps to 0x0); if haz_ifidEn=1, d_instr <= imem_data, d_pcplus4 <= PC+4, d_valid <= 1.
REQ-022 SHALL: fetch latency one cycle: word at PC appears in d_instr on the next edge.
REQ-023 SHALL: br_target used unaligned as given; no alignment check.
REQ-024 SHALL: stall_cnt increments when state=RUN and haz_pcEn=0; saturates at 16'hFFFF.
REQ-025 SHALL: imem_addr driven directly from PC register, no combinational path from any input.

Reset
REQ-026 SHALL: rst=1 sets PC=32'h0, d_instr=32'h0, d_pcplus4=0, d_valid=0, state=RUN, halted=0, stall_cnt=0.
REQ-027 SHALL: rst overrides stall, branch and HALTED in the same edge; first fetch of address 0 on first edge after rst deasserts.

Structure
REQ-028 SHALL: shared package holds OP_HALT=6'h3f, NOP_INSTR=32'h0, RESET_PC=32'h0, state encoding.
REQ-029 SHALL: OP_HALT is the same constant used by the hazard detection unit.
REQ-030 SHALL: one sub-module pipe_reg (parameterised width, enable, sync clear-to-value) used for PC and IF/ID fields.

Verification
REQ-031 SHALL: reset, imem returns 0x20010005 at 0, 0x20020006 at 4, haz enables=1 -> after 2 edges d_instr=0x20020006, d_pcplus4=8, imem_addr=8.
REQ-032 SHALL: haz_pcEn=haz_ifidEn=0 for 2 cycles at PC=0x10 -> PC and d_instr unchanged 2 cycles, stall_cnt=2, then resumes at 0x14.
REQ-033 SHALL: br_taken=1, br_target=0x40 at PC=0x0C -> next edge PC=0x40, d_valid=0, d_instr=0; following edge d_instr=imem[0x40].
REQ-034 SHALL: br_taken=1 with haz_pcEn=0 -> PC held, no flush; branch honoured next cycle when haz_pcEn=1.
REQ-035 SHALL: fetch 0xFC000000 (halt) -> one edge later halted=1, PC and IF/ID frozen for 10 further cycles despite br_taken pulses; rst returns PC=0, halted=0.
REQ-036 SHALL: PC preset via br_target=0xFFFFFFFC -> sequential edge wraps PC to 0x0, d_pcplus4=0x0.
